// File: rtl/dma_copy_engine.sv
// rtl/dma_copy_engine.sv - DMA copy/fill engine driving a dual-port synchronous RAM
//
// Copies len words from src_addr to dst_addr, or fills len words at dst_addr with
// fill_data, through a read-only RAM port 0 and a write-only RAM port 1.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   start, abort             command strobe (IDLE only), terminate active command
//   mode                     0 = copy, 1 = fill
//   src_addr, dst_addr, len  command addresses and word count (0..2^AWIDTH)
//   fill_data, wbe_mask      fill pattern and byte enables for every write
//   busy, done, aborted      status: in progress, completion pulse, abort pulse
//   addr0/en0/wbe0/d0/q0     RAM port 0 (reads; wbe0 and d0 tied to zero)
//   addr1/en1/wbe1/d1        RAM port 1 (writes)
module dma_copy_engine #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  mode,
  input  logic [AWIDTH-1:0]     src_addr,
  input  logic [AWIDTH-1:0]     dst_addr,
  input  logic [AWIDTH:0]       len,
  input  logic [DWIDTH-1:0]     fill_data,
  input  logic [DWIDTH/8-1:0]   wbe_mask,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [AWIDTH-1:0]     addr0,
  output logic                  en0,
  output logic [DWIDTH/8-1:0]   wbe0,
  output logic [DWIDTH-1:0]     d0,
  input  logic [DWIDTH-1:0]     q0,
  output logic [AWIDTH-1:0]     addr1,
  output logic                  en1,
  output logic [DWIDTH/8-1:0]   wbe1,
  output logic [DWIDTH-1:0]     d1
);

  localparam int BW = DWIDTH / 8;
  localparam logic [AWIDTH-1:0] A_ONE = 1;
  localparam logic [AWIDTH:0]   C_ONE = 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  state_t              state, state_n;
  logic                mode_r, mode_n;
  logic [AWIDTH-1:0]   rd_addr, rd_addr_n;
  logic [AWIDTH-1:0]   wr_addr, wr_addr_n;
  logic [AWIDTH:0]     cnt, cnt_n;        // reads (copy) or writes (fill) still to issue
  logic [DWIDTH-1:0]   fill_r, fill_n;
  logic [BW-1:0]       wbe_r, wbe_n;
  logic                rd_en, rd_en_n;
  logic                wr_en, wr_en_n;
  logic                abrt, abrt_n;
  logic                kill;

  // Abort only acts while a command is in flight.
  assign kill = abort && (state == RUN || state == DRAIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      mode_r  <= 1'b0;
      rd_addr <= '0;
      wr_addr <= '0;
      cnt     <= '0;
      fill_r  <= '0;
      wbe_r   <= '0;
      rd_en   <= 1'b0;
      wr_en   <= 1'b0;
      abrt    <= 1'b0;
    end else begin
      state   <= state_n;
      mode_r  <= mode_n;
      rd_addr <= rd_addr_n;
      wr_addr <= wr_addr_n;
      cnt     <= cnt_n;
      fill_r  <= fill_n;
      wbe_r   <= wbe_n;
      rd_en   <= rd_en_n;
      wr_en   <= wr_en_n;
      abrt    <= abrt_n;
    end
  end

  always_comb begin
    state_n   = state;
    mode_n    = mode_r;
    rd_addr_n = rd_addr;
    wr_addr_n = wr_addr;
    cnt_n     = cnt;
    fill_n    = fill_r;
    wbe_n     = wbe_r;
    rd_en_n   = rd_en;
    wr_en_n   = wr_en;
    abrt_n    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          mode_n    = mode;
          rd_addr_n = src_addr;
          wr_addr_n = dst_addr;
          cnt_n     = len;
          fill_n    = fill_data;
          wbe_n     = wbe_mask;
          if (len == '0) begin
            state_n = FIN;
          end else begin
            state_n = RUN;
            rd_en_n = ~mode;
            wr_en_n = mode;
          end
        end
      end
      RUN: begin
        if (kill) begin
          state_n = IDLE;
          rd_en_n = 1'b0;
          wr_en_n = 1'b0;
          abrt_n  = 1'b1;
        end else if (mode_r) begin
          if (cnt == C_ONE) begin
            state_n = FIN;
            wr_en_n = 1'b0;
          end else begin
            wr_addr_n = wr_addr + A_ONE;
            cnt_n     = cnt - C_ONE;
          end
        end else begin
          // Copy: the write stream trails the read stream by one cycle because
          // q0 arrives one cycle after the read is issued.
          rd_addr_n = rd_addr + A_ONE;
          wr_en_n   = 1'b1;
          if (wr_en) wr_addr_n = wr_addr + A_ONE;
          cnt_n = cnt - C_ONE;
          if (cnt == C_ONE) begin
            state_n = DRAIN;
            rd_en_n = 1'b0;
          end
        end
      end
      DRAIN: begin
        wr_en_n = 1'b0;
        if (kill) begin
          state_n = IDLE;
          abrt_n  = 1'b1;
        end else begin
          state_n = FIN;
        end
      end
      FIN: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Enables are gated by abort in the same cycle so the in-flight write is dropped.
  assign en0     = rd_en & ~kill;
  assign en1     = wr_en & ~kill;
  assign addr0   = rd_addr;
  assign addr1   = wr_addr;
  assign wbe1    = wbe_r;
  assign d1      = mode_r ? fill_r : q0;
  assign wbe0    = '0;
  assign d0      = '0;
  assign busy    = (state == RUN) || (state == DRAIN);
  assign done    = (state == FIN);
  assign aborted = abrt;

endmodule

// File: doc/dma_copy_engine.md
DMA_COPY_ENGINE -- requirements
Module: dma_copy_engine

Interface
REQ-001 The block SHALL have parameter DWIDTH, default 32, RAM data width (multiple of 8).
REQ-002 The block SHALL have parameter AWIDTH, default 8, RAM address width; all RAM addresses are modulo 2^AWIDTH.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  command strobe, sampled only in IDLE
- abort  in  1  terminate the active command
- mode  in  1  0 = copy, 1 = fill
- src_addr  in  AWIDTH  copy source base
- dst_addr  in  AWIDTH  destination base
- len  in  AWIDTH+1  word count, 0 to 2^AWIDTH
- fill_data  in  DWIDTH  fill pattern
- wbe_mask  in  DWIDTH/8  byte enables applied to every write
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- aborted  out  1  one-cycle abort pulse
- addr0  out  AWIDTH  RAM port 0 (read-only) address
- en0  out  1  RAM port 0 enable
- wbe0  out  DWIDTH/8  RAM port 0 byte enables, tied to 0
- d0  out  DWIDTH  RAM port 0 write data, tied to 0
- q0  in  DWIDTH  RAM port 0 read data, valid one cycle after en0
- addr1  out  AWIDTH  RAM port 1 (write-only) address
- en1  out  1  RAM port 1 enable
- wbe1  out  DWIDTH/8  RAM port 1 byte enables
- d1  out  DWIDTH  RAM port 1 write data

Function
REQ-004 The FSM SHALL have states IDLE, RUN, DRAIN and FIN.
REQ-005 In IDLE, start=1 SHALL latch mode, src_addr, dst_addr, len, fill_data and wbe_mask; later input changes SHALL have no effect until the next IDLE.
REQ-006 start SHALL be ignored outside IDLE.
REQ-007 If start is taken with len=0, the FSM SHALL go to FIN, issue no RAM access, and pulse done in the next cycle.
REQ-008 Copy, with start taken at edge T0, cycle k = 1..len:
- en0=1, addr0=(src+k-1) mod 2^AWIDTH.
REQ-009 Copy, cycle k = 2..len+1:
- en1=1, addr1=(dst+k-2) mod 2^AWIDTH, d1=q0 (combinational pass-through), wbe1=wbe_mask.
REQ-010 Copy SHALL spend cycles 1..len in RUN and cycle len+1 in DRAIN; throughput is one word per cycle.
REQ-011 Fill, cycle k = 1..len:
- en0=0, en1=1, addr1=(dst+k-1) mod 2^AWIDTH, d1=fill_data, wbe1=wbe_mask.
- DRAIN is skipped.
REQ-012 done SHALL be 1 for exactly one cycle, in FIN, immediately after the last write cycle (copy: cycle len+2; fill: cycle len+1).
REQ-013 After FIN the FSM SHALL return to IDLE; a start in the FIN cycle SHALL be ignored.
REQ-014 busy SHALL be 1 in RUN and DRAIN and 0 in IDLE and FIN.
REQ-015 en0, en1, addr0, addr1 and wbe1 SHALL come from registered FSM state; wbe1 and d1 are don't-care when en1=0.
REQ-016 Address counters SHALL wrap from 2^AWIDTH-1 to 0 silently.
REQ-017 len=2^AWIDTH SHALL touch every RAM word exactly once.
REQ-018 Overlapping ranges SHALL be copied in ascending address order with no hazard detection; the result relies on RAM read-old-data behaviour.
REQ-019 abort=1 in RUN or DRAIN SHALL have these effects:
- en0 and en1 forced to 0 in the same cycle (the in-flight write is dropped).
- Next state IDLE, aborted pulsed for one cycle, done not asserted.
REQ-020 abort SHALL be ignored in IDLE and FIN; if start and abort are both 1 in IDLE, start wins.

Reset
REQ-021 rst=1 SHALL asynchronously force the FSM to IDLE and zero all counters and outputs (busy, done, aborted, en0, en1, addr0, addr1, wbe1 = 0) at any time, including mid-command.
REQ-022 After reset, RAM writes SHALL resume only through a new start.

Verification
REQ-023 Bench against a behavioural dual-port read-first sync RAM; scenarios:
- Copy src=0x10, dst=0x80, len=4, wbe_mask=0xF -> RAM[0x80..0x83]=RAM[0x10..0x13]; en0 high cycles 1-4, en1 high cycles 2-5, done in cycle 6.
- Fill dst=0xFE, len=3, fill_data=0xA5A5A5A5, wbe_mask=0x3 -> low 16 bits of 0xFE, 0xFF, 0x00 become 0xA5A5, upper bytes unchanged; done in cycle 4.
- len=0 -> no en0/en1 pulse, done in cycle 1, busy never high.
- Copy len=8, abort in cycle 3 -> only dst+0 written; en0/en1 low in cycle 3; aborted pulse; done never high; new start accepted next cycle.
- rst asserted mid-copy, cycle 2 of len=5 -> outputs 0 immediately, no further writes; start during busy ignored; len=256 copy covers all addresses.
